gray_ptr_sync_rx: RTL and testbench

Receives a gray-coded pointer that is launched from a foreign clock domain and resynchronises it into the local domain through a parameterised flop chain. It converts the pointer to binary, optionally through a register stage, and reports each advance as a pulse together with the step size. An optional checker flags multi-bit hops for sources that are slower than the local clock. It sits on the read and write pointer crossings of the frame formatter's per-agent async FIFOs and replaces bare combinational gray-to-binary conversion at those points.

---
 rtl/gray_pkg.sv | 31 +++
 rtl/bus_sync_ff.sv | 29 ++
 rtl/gray_ptr_sync_rx.sv | 97 +++++++++
 tb/tb_gray_ptr_sync_rx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared helpers for gray-coded pointer crossings: code conversions, popcount
// and the minimum synchroniser depth.
package gray_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int PTR_MAX_W       = 32;

    // Callers zero-extend narrower pointers; bin[i] = ^gray[MSB:i] holds for any width.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned popcount(input logic [PTR_MAX_W-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            cnt += 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bus_sync_ff.sv
// Plain multi-flop synchroniser for a bus; no logic between stages so only the
// first stage can go metastable.
module bus_sync_ff #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync_rx.sv
// Receive side of a gray pointer crossing: synchronise, convert to binary,
// report advances with step size and flag illegal multi-bit hops.
module gray_ptr_sync_rx
    import gray_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int PIPE_CONV   = 1,
    parameter int HOP_CHECK   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] gray_ptr,
    output logic [WIDTH-1:0] bin_ptr,
    output logic             ptr_adv,
    output logic [WIDTH-1:0] adv_cnt,
    output logic             hop_err
);

    generate
        if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
            $error("gray_ptr_sync_rx: SYNC_STAGES below minimum");
        end
        if (WIDTH < 2 || WIDTH > PTR_MAX_W) begin : g_bad_width
            $error("gray_ptr_sync_rx: WIDTH out of range");
        end
    endgenerate

    localparam int SUP_W = $clog2(SYNC_STAGES + 2);
    // After clr the chain refills from zero; the first re-acquired value
    // reaches the compare SYNC_STAGES+1 edges later and must not count as a hop.
    localparam logic [SUP_W-1:0] SUP_LOAD = SUP_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] conv;
    logic [WIDTH-1:0] prev_bin_q;
    logic [WIDTH-1:0] adv_cnt_q, adv_cnt_d;
    logic [WIDTH-1:0] gray_prev_q;
    logic             ptr_adv_q, ptr_adv_d;
    logic             hop_err_q, hop_err_d;
    logic             hop_raw, hop_det;
    logic [SUP_W-1:0] sup_cnt_q;

    bus_sync_ff #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .d_i   (gray_in),
        .q_o   (gray_ptr)
    );

    assign conv    = WIDTH'(gray2bin(PTR_MAX_W'(gray_ptr)));
    assign hop_raw = (sup_cnt_q == '0) && (popcount(PTR_MAX_W'(gray_ptr ^ gray_prev_q)) > 1);
    assign hop_det = (HOP_CHECK != 0) && hop_raw;

    always_comb begin
        ptr_adv_d = (conv != prev_bin_q);
        adv_cnt_d = ptr_adv_d ? (conv - prev_bin_q) : adv_cnt_q;
        hop_err_d = hop_det | (hop_err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_bin_q  <= '0;
            adv_cnt_q   <= '0;
            gray_prev_q <= '0;
            ptr_adv_q   <= 1'b0;
            hop_err_q   <= 1'b0;
            sup_cnt_q   <= '0;
        end else if (clr) begin
            prev_bin_q  <= '0;
            adv_cnt_q   <= '0;
            gray_prev_q <= '0;
            ptr_adv_q   <= 1'b0;
            hop_err_q   <= 1'b0;
            sup_cnt_q   <= SUP_LOAD;
        end else begin
            prev_bin_q  <= conv;
            adv_cnt_q   <= adv_cnt_d;
            gray_prev_q <= gray_ptr;
            ptr_adv_q   <= ptr_adv_d;
            hop_err_q   <= hop_err_d;
            if (sup_cnt_q != '0) sup_cnt_q <= sup_cnt_q - 1'b1;
        end
    end

    assign bin_ptr = (PIPE_CONV != 0) ? prev_bin_q : conv;
    assign ptr_adv = ptr_adv_q;
    assign adv_cnt = adv_cnt_q;
    assign hop_err = hop_err_q;

endmodule

// File: tb/tb_gray_ptr_sync_rx.sv
// Bench for gray_ptr_sync_rx: directed vector table, hand sequences for reset,
// wrap and PIPE_CONV=0 latency, and random stimulus against a reference model.
module tb_gray_ptr_sync_rx;

    localparam int W = 6;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] gray_in = 6'b100000;
    logic         clr = 1'b0;
    logic         err_clr = 1'b0;

    logic [W-1:0] gray_ptr, bin_ptr, adv_cnt;
    logic         ptr_adv, hop_err;
    logic [W-1:0] nh_gray_ptr, nh_bin_ptr, nh_adv_cnt;
    logic         nh_ptr_adv, nh_hop_err;
    logic [W-1:0] p0_gray_ptr, p0_bin_ptr, p0_adv_cnt;
    logic         p0_ptr_adv, p0_hop_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gray_ptr_sync_rx #(.WIDTH(W), .SYNC_STAGES(S), .PIPE_CONV(1), .HOP_CHECK(1)) dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr(clr), .err_clr(err_clr),
        .gray_ptr(gray_ptr), .bin_ptr(bin_ptr), .ptr_adv(ptr_adv),
        .adv_cnt(adv_cnt), .hop_err(hop_err));

    gray_ptr_sync_rx #(.WIDTH(W), .SYNC_STAGES(S), .PIPE_CONV(1), .HOP_CHECK(0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr(clr), .err_clr(err_clr),
        .gray_ptr(nh_gray_ptr), .bin_ptr(nh_bin_ptr), .ptr_adv(nh_ptr_adv),
        .adv_cnt(nh_adv_cnt), .hop_err(nh_hop_err));

    gray_ptr_sync_rx #(.WIDTH(W), .SYNC_STAGES(3), .PIPE_CONV(0), .HOP_CHECK(1)) dut_p0 (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr(clr), .err_clr(err_clr),
        .gray_ptr(p0_gray_ptr), .bin_ptr(p0_bin_ptr), .ptr_adv(p0_ptr_adv),
        .adv_cnt(p0_adv_cnt), .hop_err(p0_hop_err));

    // Reference model: the synchroniser is an S-deep delay line, the binary value
    // is the running prefix XOR, and the step is plain modular subtraction.
    int unsigned  mq[$];
    logic [W-1:0] m_gptr = '0, m_bin = '0, m_adv = '0, m_gprev = '0;
    logic         m_pa = 1'b0, m_hop = 1'b0;
    int           m_since = 1000;

    function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int k = 0; k < W; k++) b = b ^ (g >> k);
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [W-1:0] g_cur, cv;
        if (!rst_n) begin
            mq = {};
            for (int k = 0; k < S; k++) mq.push_back(0);
            m_bin = '0; m_adv = '0; m_gprev = '0; m_pa = 1'b0; m_hop = 1'b0;
            m_since = 1000;
        end else begin
            g_cur = W'(mq[0]);
            cv    = ref_g2b(g_cur);
            if (clr) begin
                mq = {};
                for (int k = 0; k < S; k++) mq.push_back(0);
                m_bin = '0; m_adv = '0; m_gprev = '0; m_pa = 1'b0; m_hop = 1'b0;
                m_since = 0;
            end else begin
                m_pa = (cv != m_bin);
                if (m_pa) begin
                    m_adv = cv - m_bin;
                    m_bin = cv;
                end
                m_hop   = ((m_since > S) && ($countones(g_cur ^ m_gprev) > 1)) || (m_hop && !err_clr);
                m_gprev = g_cur;
                if (m_since < 1000) m_since++;
                mq.push_back(32'(gray_in));
                void'(mq.pop_front());
            end
        end
        m_gptr = W'(mq[0]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (rst_n) begin
            chk("model_gray_ptr", 32'(gray_ptr), 32'(m_gptr));
            chk("model_bin_ptr",  32'(bin_ptr),  32'(m_bin));
            chk("model_ptr_adv",  32'(ptr_adv),  32'(m_pa));
            chk("model_adv_cnt",  32'(adv_cnt),  32'(m_adv));
            chk("model_hop_err",  32'(hop_err),  32'(m_hop));
            chk("nohop_bin_ptr",  32'(nh_bin_ptr), 32'(m_bin));
            chk("nohop_hop_err",  32'(nh_hop_err), 32'd0);
        end
    endtask

    typedef struct {
        logic [W-1:0] g;
        logic         c;
        logic         e;
        logic [W-1:0] x_gptr;
        logic [W-1:0] x_bin;
        logic         x_pa;
        logic [W-1:0] x_adv;
        logic         x_hop;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [W-1:0] rp;
        int r;

        // gray, clr, err_clr | gray_ptr, bin_ptr, ptr_adv, adv_cnt, hop_err
        tbl[0]  = '{6'd0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0};
        tbl[1]  = '{6'd1, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0};
        tbl[2]  = '{6'd1, 1'b0, 1'b0, 6'd1, 6'd0, 1'b0, 6'd0, 1'b0};
        tbl[3]  = '{6'd1, 1'b0, 1'b0, 6'd1, 6'd1, 1'b1, 6'd1, 1'b0};
        tbl[4]  = '{6'd1, 1'b0, 1'b0, 6'd1, 6'd1, 1'b0, 6'd1, 1'b0};
        tbl[5]  = '{6'd2, 1'b0, 1'b0, 6'd1, 6'd1, 1'b0, 6'd1, 1'b0};
        tbl[6]  = '{6'd2, 1'b0, 1'b0, 6'd2, 6'd1, 1'b0, 6'd1, 1'b0};
        tbl[7]  = '{6'd2, 1'b0, 1'b0, 6'd2, 6'd3, 1'b1, 6'd2, 1'b1};
        tbl[8]  = '{6'd2, 1'b0, 1'b1, 6'd2, 6'd3, 1'b0, 6'd2, 1'b0};
        tbl[9]  = '{6'd2, 1'b0, 1'b0, 6'd2, 6'd3, 1'b0, 6'd2, 1'b0};
        tbl[10] = '{6'd6, 1'b0, 1'b0, 6'd2, 6'd3, 1'b0, 6'd2, 1'b0};
        tbl[11] = '{6'd7, 1'b0, 1'b0, 6'd6, 6'd3, 1'b0, 6'd2, 1'b0};
        tbl[12] = '{6'd7, 1'b0, 1'b0, 6'd7, 6'd4, 1'b1, 6'd1, 1'b0};
        tbl[13] = '{6'd7, 1'b0, 1'b0, 6'd7, 6'd5, 1'b1, 6'd1, 1'b0};
        tbl[14] = '{6'd7, 1'b0, 1'b0, 6'd7, 6'd5, 1'b0, 6'd1, 1'b0};
        tbl[15] = '{6'd7, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0};
        tbl[16] = '{6'd7, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0};
        tbl[17] = '{6'd7, 1'b0, 1'b0, 6'd7, 6'd0, 1'b0, 6'd0, 1'b0};
        tbl[18] = '{6'd7, 1'b0, 1'b0, 6'd7, 6'd5, 1'b1, 6'd5, 1'b0};
        tbl[19] = '{6'd7, 1'b0, 1'b0, 6'd7, 6'd5, 1'b0, 6'd5, 1'b0};

        // Reset held with a non-zero input: everything stays 0.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_gray_ptr", 32'(gray_ptr), 32'd0);
            chk("rst_bin_ptr",  32'(bin_ptr),  32'd0);
            chk("rst_ptr_adv",  32'(ptr_adv),  32'd0);
            chk("rst_adv_cnt",  32'(adv_cnt),  32'd0);
            chk("rst_hop_err",  32'(hop_err),  32'd0);
            chk("rst_p0_bin",   32'(p0_bin_ptr), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        tick();
        chk("rel2_ptr_adv", 32'(ptr_adv), 32'd0);
        tick();
        chk("rel3_bin_ptr", 32'(bin_ptr), 32'd63);
        chk("rel3_ptr_adv", 32'(ptr_adv), 32'd1);
        chk("rel3_adv_cnt", 32'(adv_cnt), 32'd63);
        tick();
        chk("rel4_ptr_adv", 32'(ptr_adv), 32'd0);

        for (int i = 0; i < 20; i++) begin
            gray_in = tbl[i].g;
            clr     = tbl[i].c;
            err_clr = tbl[i].e;
            tick();
            chk($sformatf("row%0d_gray_ptr", i), 32'(gray_ptr), 32'(tbl[i].x_gptr));
            chk($sformatf("row%0d_bin_ptr", i),  32'(bin_ptr),  32'(tbl[i].x_bin));
            chk($sformatf("row%0d_ptr_adv", i),  32'(ptr_adv),  32'(tbl[i].x_pa));
            chk($sformatf("row%0d_adv_cnt", i),  32'(adv_cnt),  32'(tbl[i].x_adv));
            chk($sformatf("row%0d_hop_err", i),  32'(hop_err),  32'(tbl[i].x_hop));
            if (i == 3) begin
                chk("p0_edge3_gray_ptr", 32'(p0_gray_ptr), 32'd1);
                chk("p0_edge3_bin_ptr",  32'(p0_bin_ptr),  32'd1);
                chk("p0_edge3_ptr_adv",  32'(p0_ptr_adv),  32'd0);
            end
            if (i == 4) begin
                chk("p0_edge4_ptr_adv", 32'(p0_ptr_adv), 32'd1);
                chk("p0_edge4_adv_cnt", 32'(p0_adv_cnt), 32'd1);
                chk("p0_edge4_hop_err", 32'(p0_hop_err), 32'd0);
            end
            if (i == 7) begin
                chk("nohop_row7_adv_cnt", 32'(nh_adv_cnt), 32'd2);
                chk("nohop_row7_hop_err", 32'(nh_hop_err), 32'd0);
                chk("nohop_row7_ptr_adv", 32'(nh_ptr_adv), 32'd1);
                chk("nohop_row7_gray",    32'(nh_gray_ptr), 32'd2);
            end
        end
        clr     = 1'b0;
        err_clr = 1'b0;

        // Walk one code at a time up to bin 63, then wrap to 0.
        for (int b = 6; b < 64; b++) begin
            rp      = W'(b);
            gray_in = rp ^ (rp >> 1);
            tick();
        end
        gray_in = '0;
        tick();
        tick();
        tick();
        chk("wrap_bin_ptr", 32'(bin_ptr), 32'd0);
        chk("wrap_ptr_adv", 32'(ptr_adv), 32'd1);
        chk("wrap_adv_cnt", 32'(adv_cnt), 32'd1);
        chk("wrap_hop_err", 32'(hop_err), 32'd0);

        rp = '0;
        for (int n = 0; n < 600; n++) begin
            r       = int'($urandom_range(0, 99));
            clr     = 1'b0;
            err_clr = 1'b0;
            if (r < 70)      rp = rp + W'($urandom_range(0, 2));
            else if (r < 85) rp = rp;
            else if (r < 93) rp = W'($urandom);
            else if (r < 96) err_clr = 1'b1;
            else             clr = 1'b1;
            gray_in = rp ^ (rp >> 1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
